// File: rtl/mac_t_tte_gate_sched.sv
// -----------------------------------------------------------------------------
// mac_t_tte_gate_sched
//
// Time-aware egress gate between a port's normal/TTE pointer FIFOs and the
// GMII TX MAC (sys_clk domain). A cyclic schedule counter defines a TT window
// once per period. The normal-queue empty flag is masked during the window and
// during the guard band before it, so a best-effort frame can never start if
// it might still be on the wire when the window opens. TTE traffic is never
// masked. Frame admissions and BE blocking events are counted.
//
// Ports
//   sys_clk, rstn        clock, asynchronous active-low reset
//   speed                link speed (1x = 1G, 01 = 100M, 00 = 10M)
//   sync_pulse           one-cycle strobe, restarts the schedule period
//   cfg_en               gate enable (0 = transparent)
//   cfg_cycle_len        schedule period, sys_clk cycles
//   cfg_tt_start         TT window start offset
//   cfg_tt_len           TT window length (0 = no window)
//   ptr_fifo_empty_i     normal pointer FIFO empty
//   tptr_fifo_empty_i    TTE pointer FIFO empty
//   ptr_fifo_rd          MAC read strobe, normal queue (monitored only)
//   tptr_fifo_rd         MAC read strobe, TTE queue (monitored only)
//   ptr_fifo_empty_o     gated normal empty, to the MAC
//   tptr_fifo_empty_o    TTE empty, to the MAC
//   sched_state          00 DIS, 01 OPEN, 10 GUARD, 11 TTW
//   cfg_err              shadow configuration invalid
//   be_frame_cnt         BE frames admitted (saturating)
//   tt_frame_cnt         TT frames admitted (saturating)
//   guard_block_cnt      BE blocking events (saturating)
// -----------------------------------------------------------------------------
module mac_t_tte_gate_sched #(
    parameter int CNT_W       = 20,
    parameter int MAX_FRAME_B = 1538,
    parameter int CNT_SAT     = 16
) (
    input  logic               sys_clk,
    input  logic               rstn,
    input  logic [1:0]         speed,
    input  logic               sync_pulse,
    input  logic               cfg_en,
    input  logic [CNT_W-1:0]   cfg_cycle_len,
    input  logic [CNT_W-1:0]   cfg_tt_start,
    input  logic [CNT_W-1:0]   cfg_tt_len,
    input  logic               ptr_fifo_empty_i,
    input  logic               tptr_fifo_empty_i,
    input  logic               ptr_fifo_rd,
    input  logic               tptr_fifo_rd,
    output logic               ptr_fifo_empty_o,
    output logic               tptr_fifo_empty_o,
    output logic [1:0]         sched_state,
    output logic               cfg_err,
    output logic [CNT_SAT-1:0] be_frame_cnt,
    output logic [CNT_SAT-1:0] tt_frame_cnt,
    output logic [CNT_SAT-1:0] guard_block_cnt
);

    typedef enum logic [1:0] {
        ST_DIS   = 2'b00,
        ST_OPEN  = 2'b01,
        ST_GUARD = 2'b10,
        ST_TTW   = 2'b11
    } sched_t;

    localparam logic [31:0] G_MAX = (CNT_W >= 32) ? 32'hFFFF_FFFF
                                                  : ((32'd1 << CNT_W) - 32'd1);
    localparam logic [31:0] G_RST = (32'(MAX_FRAME_B) > G_MAX) ? G_MAX
                                                               : 32'(MAX_FRAME_B);

    // Shadow configuration and schedule state
    logic [CNT_W-1:0] cyc_len_q, tt_start_q, tt_len_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] guard_q, guard_nxt;
    logic             loaded_q;   // shadow holds a real configuration
    logic             init_q;     // first cycle after reset release
    logic             en_q;
    logic             blk_q;
    sched_t           state_q, state_nxt;

    logic             cfg_bad, dis, at_end, wrap, load;
    logic             in_ttw, in_guard, gate_closed, blk;
    logic [31:0]      g_full;
    logic [CNT_W:0]   cnt_x, start_x, cyc_x, len_x, guard_x;
    logic [CNT_W:0]   since_start, to_start;

    // ---------------------------------------------------------------------
    // Configuration validity and load events
    // ---------------------------------------------------------------------
    assign cfg_bad = (cyc_len_q < CNT_W'(2)) || (tt_start_q >= cyc_len_q) ||
                     (tt_len_q >= cyc_len_q);
    assign cfg_err = loaded_q && cfg_bad;
    assign dis     = !cfg_en || !loaded_q || cfg_bad;
    assign at_end  = (cnt_q == (cyc_len_q - CNT_W'(1)));
    assign wrap    = !dis && at_end;
    // A sync coinciding with a wrap is naturally a single restart: both only
    // reload the shadow and clear the counter.
    assign load    = init_q || (cfg_en && !en_q) || sync_pulse || wrap;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            cyc_len_q  <= '0;
            tt_start_q <= '0;
            tt_len_q   <= '0;
            loaded_q   <= 1'b0;
            init_q     <= 1'b1;
            en_q       <= 1'b0;
        end else begin
            init_q <= 1'b0;
            en_q   <= cfg_en;
            if (load) begin
                cyc_len_q  <= cfg_cycle_len;
                tt_start_q <= cfg_tt_start;
                tt_len_q   <= cfg_tt_len;
                loaded_q   <= 1'b1;
            end
        end
    end

    // Schedule counter: every load event restarts the period at 0, and the
    // counter is parked at 0 while the gate is disabled.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (dis || load) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Guard band: one worst-case BE frame time at the current link speed
    // ---------------------------------------------------------------------
    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        g_full = 32'(MAX_FRAME_B);
        casez (speed)
            2'b1?:   g_full = 32'(MAX_FRAME_B);
            2'b01:   g_full = 32'(MAX_FRAME_B) * 32'd10;
            default: g_full = 32'(MAX_FRAME_B) * 32'd100;
        endcase
        guard_nxt = (g_full > G_MAX) ? G_MAX[CNT_W-1:0] : g_full[CNT_W-1:0];
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            guard_q <= G_RST[CNT_W-1:0];
        end else begin
            guard_q <= guard_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Window test, modulo the period (one extra bit avoids overflow)
    // ---------------------------------------------------------------------
    assign cnt_x   = {1'b0, cnt_q};
    assign start_x = {1'b0, tt_start_q};
    assign cyc_x   = {1'b0, cyc_len_q};
    assign len_x   = {1'b0, tt_len_q};
    assign guard_x = {1'b0, guard_q};

    assign since_start = (cnt_q >= tt_start_q) ? (cnt_x - start_x)
                                               : (cnt_x + cyc_x - start_x);
    assign to_start    = (tt_start_q >= cnt_q) ? (start_x - cnt_x)
                                               : (start_x + cyc_x - cnt_x);

    assign in_ttw   = since_start < len_x;
    // No window means no guard band either: the gate stays OPEN.
    assign in_guard = (tt_len_q != '0) && (to_start <= guard_x);

    // ---------------------------------------------------------------------
    // Schedule FSM: state register / next-state / outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_DIS;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = ST_OPEN;
        if (dis) begin
            state_nxt = ST_DIS;
        end else if (in_ttw) begin
            state_nxt = ST_TTW;
        end else if (in_guard) begin
            state_nxt = ST_GUARD;
        end
    end

    // The gate only masks the empty flag seen by an idle MAC; a frame whose
    // pointer was already read is unaffected. Reset forces both empties high
    // without waiting for a clock edge.
    always_comb begin
        gate_closed       = (state_q == ST_GUARD) || (state_q == ST_TTW);
        ptr_fifo_empty_o  = !rstn || ptr_fifo_empty_i || gate_closed;
        tptr_fifo_empty_o = !rstn || tptr_fifo_empty_i;
        sched_state       = state_q;
    end

    // ---------------------------------------------------------------------
    // Saturating statistics
    // ---------------------------------------------------------------------
    assign blk = !ptr_fifo_empty_i && gate_closed;

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            be_frame_cnt    <= '0;
            tt_frame_cnt    <= '0;
            guard_block_cnt <= '0;
            blk_q           <= 1'b0;
        end else begin
            blk_q <= blk;
            if (ptr_fifo_rd && (be_frame_cnt != '1)) begin
                be_frame_cnt <= be_frame_cnt + CNT_SAT'(1);
            end
            if (tptr_fifo_rd && (tt_frame_cnt != '1)) begin
                tt_frame_cnt <= tt_frame_cnt + CNT_SAT'(1);
            end
            // One event per blocking episode, not per blocked cycle.
            if (blk && !blk_q && (guard_block_cnt != '1)) begin
                guard_block_cnt <= guard_block_cnt + CNT_SAT'(1);
            end
        end
    end

endmodule
